mult_div_sequencer: RTL
=======================

// Module: mult_div_sequencer
// PURPOSE
// - Multi-cycle multiply/divide unit for the E stage; owns the HI/LO registers and times their latency.
// - Accepts one operation at a time via start/md_op and holds busy for a fixed cycle count.
// - Drives md_stall, which the hazard logic ORs into StallD/StallF/FlushE.
// - MFHI/MFLO read hi_out/lo_out directly through the E-stage result mux.
// PARAMETERS
// - MULT_CYCLES  5   busy cycles for MULT/MULTU (and MADD*/MSUB* when enabled); must be >= 1
// - DIV_CYCLES   10  busy cycles for DIV/DIVU; must be >= 1
// PORTS
// - clk         in   1   clock, rising edge
// - reset       in   1   synchronous, active-low reset
// - start       in   1   E-stage instruction is an md_op; qualifies md_op for one cycle
// - md_op       in   4   0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,7 MADD,8 MADDU,9 MSUB,10 MSUBU
// - operand_a   in   32  forwarded rs value (E stage)
// - operand_b   in   32  forwarded rt value (E stage)
// - md_use_d    in   1   D-stage instruction is any mult/div/mthi/mtlo/mfhi/mflo
// - busy        out  1   operation in flight
// - md_stall    out  1   stall request to hazard logic
// - hi_out      out  32  architectural HI
// - lo_out      out  32  architectural LO
// BEHAVIOUR
// - Reset (reset==0 at edge): state IDLE, cnt=0, busy=0, hi_out=0, lo_out=0, shadow result cleared.
// - Reset mid-operation aborts it; HI/LO are not updated.
// - States: IDLE (cnt==0) and RUN (cnt!=0); busy = (cnt!=0), registered-derived, no combinational path from start.
// - IDLE & start & op in {MULT,MULTU} -> compute 64-bit product into shadow, cnt<=MULT_CYCLES, go RUN.
// - IDLE & start & op in {DIV,DIVU} -> compute quotient/remainder into shadow, cnt<=DIV_CYCLES, go RUN.
// - RUN: cnt decrements each edge. On the edge where cnt goes 1->0, {HI,LO}<=shadow and state returns to IDLE.
// - Timing: start sampled at edge t0 -> busy=1 after edges t0..t0+N-1 (N cycles).
//   New HI/LO visible after edge t0+N, and busy=0 in that same cycle.
// - MTHI/MTLO in IDLE: hi_out/lo_out <= operand_a at the next edge; 1-cycle, busy stays 0.
// - start while RUN: ignored (md_stall prevents this). Inputs are not relatched.
// - start with md_op NONE or an undefined code: no effect.
// - MULT: signed 32x32 -> 64. MULTU: unsigned. HI = product[63:32], LO = product[31:0].
// - DIV/DIVU: LO = quotient, HI = remainder. Signed division truncates toward zero; remainder takes the dividend's sign.
// - Signed 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
// - Divide by zero (either signedness): HI/LO unchanged at completion; busy still lasts DIV_CYCLES.
// - md_stall = md_use_d & (busy | start). Purely combinational.
// - Holds a D-stage HI/LO consumer while E issues or an op is in flight.
// CONFIGURATION
// - Macro MD_MADD_EN defined: ops 7..10 are legal and take MULT_CYCLES.
//   - Committed value = {HI,LO} +/- product, mod 2^64.
//   - MADD/MSUB use the signed product; MADDU/MSUBU use the unsigned product.
//   - The {HI,LO} operand is sampled at start.
// - MD_MADD_EN undefined: ops 7..10 are treated as NONE (no busy, no HI/LO change); no accumulator logic is synthesized.
// TESTING
// - Reset: hold reset=0 for 2 cycles, release -> busy=0, md_stall=0, hi_out=lo_out=0.
// - MULT 0xFFFFFFFF*0x00000002 -> busy for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
//   MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
// - DIV 0xFFFFFFF9(-7)/2 -> busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//   DIVU 7/0 -> HI/LO unchanged after 10 cycles.
// - Hazard: MULT issued with md_use_d=1 -> md_stall=1 in the start cycle and all 5 busy cycles, 0 once busy drops.
//   With md_use_d=0, md_stall stays 0 throughout.
// - MTLO 0x12345678 then MTHI 0x9ABCDEF0 on consecutive cycles -> lo_out/hi_out update one edge later each; busy stays 0.
//   reset=0 at cycle 3 of a DIV -> busy=0 and HI=LO=0 next cycle.
// - MD_MADD_EN: HI=0, LO=0xFFFFFFFF, MADDU 1*1 -> HI=1, LO=0 after 5 cycles.
//   Without the macro the same op leaves HI=0, LO=0xFFFFFFFF and busy=0.

Source files
------------

// File: rtl/mult_div_sequencer.sv
// mult_div_sequencer: multi-cycle multiply/divide unit for the E stage.
// Owns the architectural HI/LO registers. The result is computed into a
// shadow register when the operation is accepted, and is committed to HI/LO
// after a fixed number of busy cycles.
// Optional feature: define MD_MADD_EN to enable MADD/MADDU/MSUB/MSUBU
// (multiply-accumulate into {HI,LO}).
module mult_div_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic        md_use_d,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    // Signed 32x32 -> 64 product (operands sign-extended to 64 bits).
    function automatic logic [63:0] mul_signed(input logic [31:0] a, input logic [31:0] b);
        return $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    endfunction

    // Unsigned 32x32 -> 64 product.
    function automatic logic [63:0] mul_unsigned(input logic [31:0] a, input logic [31:0] b);
        return {32'h0000_0000, a} * {32'h0000_0000, b};
    endfunction

    // Signed divide returning {remainder, quotient}; the one overflow case
    // (most-negative / -1) is pinned so no simulator-dependent result leaks out.
    function automatic logic [63:0] div_signed(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'h0000_0000) begin
            q = 32'h0000_0000;
            r = 32'h0000_0000;
        end else if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
            q = 32'h8000_0000;
            r = 32'h0000_0000;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
        return {r, q};
    endfunction

    // Unsigned divide returning {remainder, quotient}.
    function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'h0000_0000) begin
            q = 32'h0000_0000;
            r = 32'h0000_0000;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [63:0]      shadow_r, shadow_s;
    logic [31:0]      hi_r, hi_s;
    logic [31:0]      lo_r, lo_s;
    logic             busy_r;

    // Next-state, counter, shadow result and HI/LO update logic.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        shadow_s = shadow_r;
        hi_s     = hi_r;
        lo_s     = lo_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    case (md_op)
                        OP_MULT: begin
                            shadow_s = mul_signed(operand_a, operand_b);
                            cnt_s    = MULT_CNT;
                            state_s  = ST_RUN;
                        end
                        OP_MULTU: begin
                            shadow_s = mul_unsigned(operand_a, operand_b);
                            cnt_s    = MULT_CNT;
                            state_s  = ST_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            // Divide by zero commits the current HI/LO back unchanged.
                            if (operand_b == 32'h0000_0000) begin
                                shadow_s = {hi_r, lo_r};
                            end else if (md_op == OP_DIV) begin
                                shadow_s = div_signed(operand_a, operand_b);
                            end else begin
                                shadow_s = div_unsigned(operand_a, operand_b);
                            end
                            cnt_s   = DIV_CNT;
                            state_s = ST_RUN;
                        end
                        OP_MTHI: hi_s = operand_a;
                        OP_MTLO: lo_s = operand_a;
`ifdef MD_MADD_EN
                        OP_MADD: begin
                            shadow_s = {hi_r, lo_r} + mul_signed(operand_a, operand_b);
                            cnt_s    = MULT_CNT;
                            state_s  = ST_RUN;
                        end
                        OP_MADDU: begin
                            shadow_s = {hi_r, lo_r} + mul_unsigned(operand_a, operand_b);
                            cnt_s    = MULT_CNT;
                            state_s  = ST_RUN;
                        end
                        OP_MSUB: begin
                            shadow_s = {hi_r, lo_r} - mul_signed(operand_a, operand_b);
                            cnt_s    = MULT_CNT;
                            state_s  = ST_RUN;
                        end
                        OP_MSUBU: begin
                            shadow_s = {hi_r, lo_r} - mul_unsigned(operand_a, operand_b);
                            cnt_s    = MULT_CNT;
                            state_s  = ST_RUN;
                        end
`endif
                        default: state_s = ST_IDLE;
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == CNT_ONE) begin
                    cnt_s   = CNT_ZERO;
                    hi_s    = shadow_r[63:32];
                    lo_s    = shadow_r[31:0];
                    state_s = ST_IDLE;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, counter, shadow and HI/LO registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= CNT_ZERO;
            shadow_r <= 64'h0;
            hi_r     <= 32'h0000_0000;
            lo_r     <= 32'h0000_0000;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            shadow_r <= shadow_s;
            hi_r     <= hi_s;
            lo_r     <= lo_s;
            busy_r   <= (cnt_s != CNT_ZERO);
        end
    end

    assign busy     = busy_r;
    assign hi_out   = hi_r;
    assign lo_out   = lo_r;
    // Stall is intentionally combinational on start so the issuing cycle is covered.
    assign md_stall = md_use_d & (busy_r | start);

endmodule
